// File: rtl/vga_timing_pkg.sv
// Shared 640x480@60 timing defaults, coordinate type and vertical region encoding
// for the VGA sync path.
package vga_timing_pkg;

  localparam int COORD_W = 10;

  localparam int DEF_H_VISIBLE = 640;
  localparam int DEF_H_FP      = 16;
  localparam int DEF_H_SYNC    = 96;
  localparam int DEF_H_BP      = 48;

  localparam int DEF_V_VISIBLE = 480;
  localparam int DEF_V_FP      = 10;
  localparam int DEF_V_SYNC    = 2;
  localparam int DEF_V_BP      = 33;

  typedef logic [COORD_W-1:0] coord_t;

  typedef enum logic [1:0] {
    REG_ACTIVE = 2'd0,
    REG_FRONT  = 2'd1,
    REG_SYNC   = 2'd2,
    REG_BACK   = 2'd3
  } v_region_t;

  // Region a line number belongs to; anything past the sync region reads as back porch.
  function automatic v_region_t region_of(input coord_t line, input int vis,
                                          input int fp, input int sync);
    int l;
    l = int'(line);
    if (l < vis)                 return REG_ACTIVE;
    else if (l < vis + fp)       return REG_FRONT;
    else if (l < vis + fp + sync) return REG_SYNC;
    else                         return REG_BACK;
  endfunction

endpackage

// File: rtl/vline_counter.sv
// Line counter plus vertical region state machine, stepped once per line by
// the upstream end-of-line strobe.
module vline_counter
  import vga_timing_pkg::*;
#(
  parameter int V_VISIBLE = DEF_V_VISIBLE,
  parameter int V_FP      = DEF_V_FP,
  parameter int V_SYNC    = DEF_V_SYNC,
  parameter int V_BP      = DEF_V_BP
) (
  input  logic      clk,
  input  logic      rst,
  input  logic      enable_vsync,
  output coord_t    vcount,
  output v_region_t region
);

  localparam int     V_TOTAL     = V_VISIBLE + V_FP + V_SYNC + V_BP;
  localparam coord_t LAST_ACTIVE = coord_t'(V_VISIBLE - 1);
  localparam coord_t LAST_FRONT  = coord_t'(V_VISIBLE + V_FP - 1);
  localparam coord_t LAST_SYNC   = coord_t'(V_VISIBLE + V_FP + V_SYNC - 1);
  localparam coord_t LAST_LINE   = coord_t'(V_TOTAL - 1);

  coord_t    vcount_reg, vcount_next;
  v_region_t region_reg, region_next;
  logic      consistent;

  always_ff @(posedge clk) begin
    if (rst) begin
      vcount_reg <= '0;
      region_reg <= REG_ACTIVE;
    end else begin
      vcount_reg <= vcount_next;
      region_reg <= region_next;
    end
  end

  always_comb begin
    vcount_next = vcount_reg;
    region_next = region_reg;
    consistent  = (region_reg == region_of(vcount_reg, V_VISIBLE, V_FP, V_SYNC));

    if (enable_vsync) begin
      // A state/line mismatch or the last line both restart the frame cleanly.
      if (!consistent || vcount_reg >= LAST_LINE) begin
        vcount_next = '0;
        region_next = REG_ACTIVE;
      end else begin
        vcount_next = vcount_reg + 10'd1;
        case (region_reg)
          REG_ACTIVE: if (vcount_reg == LAST_ACTIVE) region_next = REG_FRONT;
          REG_FRONT:  if (vcount_reg == LAST_FRONT)  region_next = REG_SYNC;
          REG_SYNC:   if (vcount_reg == LAST_SYNC)   region_next = REG_BACK;
          REG_BACK:   region_next = REG_BACK;
          default:    region_next = REG_ACTIVE;
        endcase
      end
    end
  end

  assign vcount = vcount_reg;
  assign region = region_reg;

endmodule

// File: rtl/vga_sync_gen.sv
// Vertical timing and sync generator: horizontal decode of the upstream pixel
// count, line tracking, and one-cycle-latency registered video timing outputs.
module vga_sync_gen
  import vga_timing_pkg::*;
#(
  parameter int   H_VISIBLE = DEF_H_VISIBLE,
  parameter int   H_FP      = DEF_H_FP,
  parameter int   H_SYNC    = DEF_H_SYNC,
  parameter int   V_VISIBLE = DEF_V_VISIBLE,
  parameter int   V_FP      = DEF_V_FP,
  parameter int   V_SYNC    = DEF_V_SYNC,
  parameter int   V_BP      = DEF_V_BP,
  parameter logic SYNC_POL  = 1'b0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [COORD_W-1:0] hcount,
  input  logic               enable_vsync,
  output logic               hsync,
  output logic               vsync,
  output logic               video_on,
  output logic [COORD_W-1:0] pixel_x,
  output logic [COORD_W-1:0] pixel_y,
  output logic [COORD_W-1:0] vcount,
  output logic               frame_tick
);

  localparam coord_t H_VIS_END    = coord_t'(H_VISIBLE);
  localparam coord_t H_SYNC_START = coord_t'(H_VISIBLE + H_FP);
  localparam coord_t H_SYNC_END   = coord_t'(H_VISIBLE + H_FP + H_SYNC);
  localparam coord_t H_TOTAL      = coord_t'(H_VISIBLE + H_FP + H_SYNC + DEF_H_BP);
  localparam coord_t V_BLANK_LINE = coord_t'(V_VISIBLE);

  v_region_t region;
  coord_t    line;
  logic      h_legal, h_visible, h_sync_on, visible, tick_now;

  logic   hsync_reg, vsync_reg, video_on_reg, frame_tick_reg;
  coord_t pixel_x_reg, pixel_y_reg;

  vline_counter #(
    .V_VISIBLE (V_VISIBLE),
    .V_FP      (V_FP),
    .V_SYNC    (V_SYNC),
    .V_BP      (V_BP)
  ) u_vline (
    .clk          (clk),
    .rst          (rst),
    .enable_vsync (enable_vsync),
    .vcount       (line),
    .region       (region)
  );

  // Out-of-range pixel counts fall through as blanking with sync released.
  always_comb begin
    h_legal   = (hcount < H_TOTAL);
    h_visible = h_legal && (hcount < H_VIS_END);
    h_sync_on = h_legal && (hcount >= H_SYNC_START) && (hcount < H_SYNC_END);
    visible   = h_visible && (region == REG_ACTIVE);
    tick_now  = (line == V_BLANK_LINE) && (hcount == '0);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hsync_reg      <= ~SYNC_POL;
      vsync_reg      <= ~SYNC_POL;
      video_on_reg   <= 1'b0;
      pixel_x_reg    <= '0;
      pixel_y_reg    <= '0;
      frame_tick_reg <= 1'b0;
    end else begin
      hsync_reg      <= h_sync_on ? SYNC_POL : ~SYNC_POL;
      vsync_reg      <= (region == REG_SYNC) ? SYNC_POL : ~SYNC_POL;
      video_on_reg   <= visible;
      pixel_x_reg    <= visible ? hcount : '0;
      pixel_y_reg    <= visible ? line : '0;
      frame_tick_reg <= tick_now;
    end
  end

  assign hsync      = hsync_reg;
  assign vsync      = vsync_reg;
  assign video_on   = video_on_reg;
  assign pixel_x    = pixel_x_reg;
  assign pixel_y    = pixel_y_reg;
  assign vcount     = line;
  assign frame_tick = frame_tick_reg;

endmodule

// File: tb/tb_vga_sync_gen.sv
// Directed bench for vga_sync_gen: vector table for decode/reset corners, then
// compressed frames (only lines of interest run full length) for vertical timing.
module tb_vga_sync_gen;

  logic       clk = 1'b0;
  logic       rst;
  logic [9:0] hcount;
  logic       enable_vsync;
  logic       hsync, vsync, video_on, frame_tick;
  logic [9:0] pixel_x, pixel_y, vcount;

  always #5 clk = ~clk;

  vga_sync_gen dut (
    .clk          (clk),
    .rst          (rst),
    .hcount       (hcount),
    .enable_vsync (enable_vsync),
    .hsync        (hsync),
    .vsync        (vsync),
    .video_on     (video_on),
    .pixel_x      (pixel_x),
    .pixel_y      (pixel_y),
    .vcount       (vcount),
    .frame_tick   (frame_tick)
  );

  typedef struct {
    logic r; int h; logic en;
    logic hs; logic vs; logic vo; int px; int py; int vc; logic tk;
  } vec_t;

  // 9 full-length lines (10, 479, 480, 488..493) plus 516 two-cycle lines.
  localparam int FRAME_CYC = 9 * 800 + (525 - 9) * 2;

  int checks = 0, errors = 0;
  int cyc = 0, ln = 0, cur_line = 0, cur_h = 0;
  int vs_low, vs_bad, vo_late, vo_l10, hs_l10, tick_cnt;
  int spurious = 0, missed = 0, vc_bad = 0;
  logic hs_at [4];
  int tick_cyc[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic clear_acc();
    vs_low = 0; vs_bad = 0; vo_late = 0; vo_l10 = 0; hs_l10 = 0; tick_cnt = 0;
  endtask

  task automatic step(input logic r, input int h, input logic en);
    rst = r; hcount = h[9:0]; enable_vsync = en;
    cur_line = ln; cur_h = h;
    @(posedge clk); #1;
    cyc++;
    if (r) ln = 0;
    else if (en) ln = (ln == 524) ? 0 : ln + 1;
    if (vcount !== ln[9:0]) vc_bad++;
    if (frame_tick === 1'b1) begin
      tick_cnt++;
      if (r || cur_line != 480 || cur_h != 0) spurious++;
      else tick_cyc.push_back(cyc);
    end else if (!r && cur_line == 480 && cur_h == 0) missed++;
    if (!r) begin
      if (vsync === 1'b0) begin
        vs_low++;
        if (cur_line < 490 || cur_line > 491) vs_bad++;
      end
      if (video_on === 1'b1 && cur_line >= 480) vo_late++;
      if (cur_line == 10) begin
        if (video_on === 1'b1) vo_l10++;
        if (hsync === 1'b0) hs_l10++;
        if (cur_h == 655) hs_at[0] = hsync;
        if (cur_h == 656) hs_at[1] = hsync;
        if (cur_h == 751) hs_at[2] = hsync;
        if (cur_h == 752) hs_at[3] = hsync;
      end
    end
  endtask

  function automatic bit is_full(input int l);
    return (l == 10) || (l == 479) || (l == 480) || (l >= 488 && l <= 493);
  endfunction

  task automatic run_line(input bit full);
    if (full) begin
      for (int h = 0; h < 800; h++) step(1'b0, h, h == 799);
    end else begin
      step(1'b0, 0, 1'b0);
      step(1'b0, 799, 1'b1);
    end
  endtask

  vec_t tbl [19];
  int en_count;
  bit found;

  initial begin
    //            r     h     en    hs    vs    vo    px   py vc tk
    tbl[0]  = '{1'b1,    0, 1'b0, 1'b1, 1'b1, 1'b0,   0, 0, 0, 1'b0};
    tbl[1]  = '{1'b1,    0, 1'b0, 1'b1, 1'b1, 1'b0,   0, 0, 0, 1'b0};
    tbl[2]  = '{1'b1,    0, 1'b0, 1'b1, 1'b1, 1'b0,   0, 0, 0, 1'b0};
    tbl[3]  = '{1'b0,    0, 1'b0, 1'b1, 1'b1, 1'b1,   0, 0, 0, 1'b0};
    tbl[4]  = '{1'b0,    5, 1'b0, 1'b1, 1'b1, 1'b1,   5, 0, 0, 1'b0};
    tbl[5]  = '{1'b0,  639, 1'b0, 1'b1, 1'b1, 1'b1, 639, 0, 0, 1'b0};
    tbl[6]  = '{1'b0,  640, 1'b0, 1'b1, 1'b1, 1'b0,   0, 0, 0, 1'b0};
    tbl[7]  = '{1'b0,  655, 1'b0, 1'b1, 1'b1, 1'b0,   0, 0, 0, 1'b0};
    tbl[8]  = '{1'b0,  656, 1'b0, 1'b0, 1'b1, 1'b0,   0, 0, 0, 1'b0};
    tbl[9]  = '{1'b0,  751, 1'b0, 1'b0, 1'b1, 1'b0,   0, 0, 0, 1'b0};
    tbl[10] = '{1'b0,  752, 1'b0, 1'b1, 1'b1, 1'b0,   0, 0, 0, 1'b0};
    tbl[11] = '{1'b0,  800, 1'b0, 1'b1, 1'b1, 1'b0,   0, 0, 0, 1'b0};
    tbl[12] = '{1'b0, 1023, 1'b0, 1'b1, 1'b1, 1'b0,   0, 0, 0, 1'b0};
    tbl[13] = '{1'b0,  799, 1'b1, 1'b1, 1'b1, 1'b0,   0, 0, 1, 1'b0};
    tbl[14] = '{1'b0,  100, 1'b0, 1'b1, 1'b1, 1'b1, 100, 1, 1, 1'b0};
    tbl[15] = '{1'b1,  799, 1'b1, 1'b1, 1'b1, 1'b0,   0, 0, 0, 1'b0};
    tbl[16] = '{1'b0,    3, 1'b0, 1'b1, 1'b1, 1'b1,   3, 0, 0, 1'b0};
    tbl[17] = '{1'b0,  799, 1'b1, 1'b1, 1'b1, 1'b0,   0, 0, 1, 1'b0};
    tbl[18] = '{1'b0,  700, 1'b0, 1'b0, 1'b1, 1'b0,   0, 0, 1, 1'b0};

    for (int i = 0; i < 19; i++) begin
      step(tbl[i].r, tbl[i].h, tbl[i].en);
      checks++;
      if (hsync !== tbl[i].hs || vsync !== tbl[i].vs || video_on !== tbl[i].vo ||
          pixel_x !== tbl[i].px[9:0] || pixel_y !== tbl[i].py[9:0] ||
          vcount !== tbl[i].vc[9:0] || frame_tick !== tbl[i].tk) begin
        errors++;
        $display("FAIL vec%0d: got hs=%b vs=%b vo=%b px=%0d py=%0d vc=%0d tk=%b expected hs=%b vs=%b vo=%b px=%0d py=%0d vc=%0d tk=%b",
                 i, hsync, vsync, video_on, pixel_x, pixel_y, vcount, frame_tick,
                 tbl[i].hs, tbl[i].vs, tbl[i].vo, tbl[i].px, tbl[i].py, tbl[i].vc, tbl[i].tk);
      end
      $display("vec%0d h=%0d en=%b rst=%b -> hs=%b vs=%b vo=%b px=%0d py=%0d vc=%0d",
               i, tbl[i].h, tbl[i].en, tbl[i].r, hsync, vsync, video_on, pixel_x, pixel_y, vcount);
    end

    // Three compressed frames from a clean line 0.
    step(1'b1, 0, 1'b0);
    for (int f = 0; f < 3; f++) begin
      clear_acc();
      for (int l = 0; l < 525; l++) run_line(is_full(l));
      check($sformatf("f%0d_vsync_low_cycles", f), vs_low, 1600);
      check($sformatf("f%0d_vsync_outside_490_491", f), vs_bad, 0);
      check($sformatf("f%0d_video_on_in_blank", f), vo_late, 0);
      check($sformatf("f%0d_video_on_line10", f), vo_l10, 640);
      check($sformatf("f%0d_hsync_low_line10", f), hs_l10, 96);
      check($sformatf("f%0d_tick_count", f), tick_cnt, 1);
      check($sformatf("f%0d_vcount_wrap", f), vcount, 0);
      $display("frame%0d vsync_low=%0d hsync_low_l10=%0d video_on_l10=%0d ticks=%0d",
               f, vs_low, hs_l10, vo_l10, tick_cnt);
      if (f == 0) begin
        check("hsync_at_655", hs_at[0], 1);
        check("hsync_at_656", hs_at[1], 0);
        check("hsync_at_751", hs_at[2], 0);
        check("hsync_at_752", hs_at[3], 1);
      end
    end
    check("tick_total", tick_cyc.size(), 3);
    if (tick_cyc.size() == 3) begin
      check("tick_spacing_1_2", tick_cyc[1] - tick_cyc[0], FRAME_CYC);
      check("tick_spacing_2_3", tick_cyc[2] - tick_cyc[1], FRAME_CYC);
    end

    // Mid-frame reset at line 300, hcount 200.
    for (int l = 0; l < 300; l++) run_line(1'b0);
    for (int h = 0; h < 200; h++) step(1'b0, h, 1'b0);
    check("pre_reset_video_on", video_on, 1);
    step(1'b1, 200, 1'b0);
    check("rst_vcount", vcount, 0);
    check("rst_video_on", video_on, 0);
    check("rst_hsync", hsync, 1);
    check("rst_vsync", vsync, 1);
    check("rst_frame_tick", frame_tick, 0);
    check("rst_pixel_xy", {pixel_x, pixel_y}, 0);
    $display("midframe reset: vc=%0d vo=%b hs=%b vs=%b tk=%b", vcount, video_on, hsync, vsync, frame_tick);
    for (int h = 201; h < 800; h++) step(1'b0, h, h == 799);
    en_count = 1;
    found = 0;
    while (!found && en_count < 600) begin
      step(1'b0, 0, 1'b0);
      if (vsync === 1'b0) found = 1;
      else begin
        step(1'b0, 799, 1'b1);
        en_count++;
      end
    end
    check("vsync_found_after_reset", found, 1);
    check("lines_to_first_vsync", en_count, 490);
    $display("first vsync after reset at line %0d", en_count);

    // Reset coinciding with the end of line 524.
    if (found) begin
      step(1'b0, 799, 1'b1);
      for (int l = 491; l < 524; l++) run_line(1'b0);
      step(1'b0, 0, 1'b0);
      check("pre_sim_vcount", vcount, 524);
      step(1'b1, 799, 1'b1);
      check("sim_rst_vcount", vcount, 0);
      check("sim_rst_video_on", video_on, 0);
      step(1'b0, 0, 1'b0);
      check("sim_after_video_on", video_on, 1);
      check("sim_after_vcount", vcount, 0);
      step(1'b0, 799, 1'b1);
      check("sim_single_advance", vcount, 1);
      step(1'b0, 5, 1'b0);
      check("sim_pixel_y", pixel_y, 1);
      $display("simultaneous rst/enable: vc=%0d py=%0d", vcount, pixel_y);
    end

    check("spurious_ticks", spurious, 0);
    check("missed_ticks", missed, 0);
    check("vcount_tracking", vc_bad, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
